// File: rtl/ql_pkg.sv
// Shared Q-learning definitions: default table widths, issue FSM encoding, LFSR taps.
package ql_pkg;

  localparam int unsigned QL_STATE_W  = 6;
  localparam int unsigned QL_ACTION_W = 2;
  localparam int unsigned QL_LFSR_W   = 16;
  localparam int unsigned QL_CNT_W    = 16;

  // Galois feedback mask for the right-shifting 16-bit LFSR
  localparam logic [QL_LFSR_W-1:0] QL_LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_NS = 2'd2
  } ql_fsm_e;

endpackage

// File: rtl/ql_lfsr16.sv
// 16-bit right-shifting Galois LFSR; advances one step per cycle while i_en is high.
module ql_lfsr16
  import ql_pkg::*;
#(
  parameter logic [QL_LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  output logic [QL_LFSR_W-1:0] o_value
);

  logic [QL_LFSR_W-1:0] lfsr_q, lfsr_d;

  // Next value: shift right, fold in the mask when the bit shifted out is 1
  always_comb begin
    lfsr_d = lfsr_q;
    if (i_en) begin
      lfsr_d = {1'b0, lfsr_q[QL_LFSR_W-1:1]} ^ (lfsr_q[0] ? QL_LFSR_MASK : '0);
    end
  end

  // LFSR register, reloaded with the seed on reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign o_value = lfsr_q;

endmodule

// File: rtl/qlearn_sa_gen.sv
// Issue stage of the Q-learning pipeline: offers {state, action} pairs, waits for
// the returned next state and tracks episode/run boundaries.
// Optional: define QL_STEP_LIMIT_EN to also end an episode after MAX_STEPS steps.
module qlearn_sa_gen
  import ql_pkg::*;
#(
  parameter int unsigned          STATE_W      = QL_STATE_W,
  parameter int unsigned          ACTION_W     = QL_ACTION_W,
  parameter int unsigned          START_STATE  = 0,
  parameter int unsigned          END_STATE    = 63,
  parameter int unsigned          MAX_STEPS    = 255,
  parameter int unsigned          NUM_EPISODES = 16,
  parameter logic [QL_LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  output logic                        o_sa_valid,
  input  logic                        i_sa_ready,
  output logic [STATE_W-1:0]          o_state,
  output logic [ACTION_W-1:0]         o_action,
  output logic [STATE_W+ACTION_W-1:0] o_addr,
  input  logic                        i_ns_valid,
  input  logic [STATE_W-1:0]          i_ns,
  output logic                        o_episode_done,
  output logic [QL_CNT_W-1:0]         o_episode_cnt,
  output logic [QL_CNT_W-1:0]         o_step_cnt,
  output logic                        o_busy,
  output logic                        o_run_done
);

  localparam int unsigned         CNT_W   = QL_CNT_W;
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;
  localparam logic [STATE_W-1:0]  START_S = STATE_W'(START_STATE);
  localparam logic [STATE_W-1:0]  END_S   = STATE_W'(END_STATE);

  ql_fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0]    state_q, state_d;
  logic [ACTION_W-1:0]   action_q, action_d;
  logic [CNT_W-1:0]      step_q, step_d;
  logic [CNT_W-1:0]      ep_q, ep_d;
  logic                  valid_q, valid_d;
  logic                  ep_done_q, ep_done_d;
  logic                  run_done_q, run_done_d;
  logic                  busy_q, busy_d;

  logic [QL_LFSR_W-1:0]  lfsr_value;
  logic                  handshake;
  logic [CNT_W:0]        step_inc, ep_inc;
  logic [CNT_W-1:0]      step_sat, ep_sat;
  logic                  limit_hit, ep_end, run_end;
  logic                  unused_lfsr_hi;

  assign handshake      = (fsm_q == ST_ISSUE) && i_sa_ready;
  assign unused_lfsr_hi = ^lfsr_value[QL_LFSR_W-1:ACTION_W];

  ql_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (handshake),
    .o_value (lfsr_value)
  );

  // Saturating increments and episode/run termination conditions
  always_comb begin
    step_inc = (CNT_W+1)'(step_q) + (CNT_W+1)'(1);
    ep_inc   = (CNT_W+1)'(ep_q) + (CNT_W+1)'(1);
    step_sat = (step_q == CNT_MAX) ? step_q : step_inc[CNT_W-1:0];
    ep_sat   = (ep_q == CNT_MAX) ? ep_q : ep_inc[CNT_W-1:0];
`ifdef QL_STEP_LIMIT_EN
    limit_hit = (step_inc == (CNT_W+1)'(MAX_STEPS));
`else
    limit_hit = 1'b0;
`endif
    ep_end  = (i_ns == END_S) || limit_hit;
    run_end = ep_end && (NUM_EPISODES != 0) && (ep_inc == (CNT_W+1)'(NUM_EPISODES));
  end

`ifndef QL_STEP_LIMIT_EN
  logic unused_max_steps;
  assign unused_max_steps = ^(CNT_W+1)'(MAX_STEPS);
`endif

  // Next-state and next-output logic for the issue FSM
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    action_d   = action_q;
    step_d     = step_q;
    ep_d       = ep_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    ep_done_d  = 1'b0;
    run_done_d = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        if (i_start) begin
          fsm_d    = ST_ISSUE;
          state_d  = START_S;
          action_d = lfsr_value[ACTION_W-1:0];
          step_d   = '0;
          ep_d     = '0;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (i_sa_ready) begin
          fsm_d   = ST_WAIT_NS;
          valid_d = 1'b0;
        end
      end
      ST_WAIT_NS: begin
        if (i_ns_valid) begin
          step_d  = step_sat;
          state_d = i_ns;
          if (ep_end) begin
            ep_done_d = 1'b1;
            ep_d      = ep_sat;
            state_d   = START_S;
            step_d    = '0;
          end
          if (run_end) begin
            run_done_d = 1'b1;
            busy_d     = 1'b0;
            fsm_d      = ST_IDLE;
          end else begin
            fsm_d    = ST_ISSUE;
            valid_d  = 1'b1;
            action_d = lfsr_value[ACTION_W-1:0];
          end
        end
      end
      default: begin
        fsm_d   = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any outstanding offer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q      <= ST_IDLE;
      state_q    <= START_S;
      action_q   <= '0;
      step_q     <= '0;
      ep_q       <= '0;
      valid_q    <= 1'b0;
      ep_done_q  <= 1'b0;
      run_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      action_q   <= action_d;
      step_q     <= step_d;
      ep_q       <= ep_d;
      valid_q    <= valid_d;
      ep_done_q  <= ep_done_d;
      run_done_q <= run_done_d;
      busy_q     <= busy_d;
    end
  end

  assign o_sa_valid     = valid_q;
  assign o_state        = state_q;
  assign o_action       = action_q;
  assign o_addr         = {state_q, action_q};
  assign o_episode_done = ep_done_q;
  assign o_episode_cnt  = ep_q;
  assign o_step_cnt     = step_q;
  assign o_busy         = busy_q;
  assign o_run_done     = run_done_q;

endmodule

// File: tb/tb_qlearn_sa_gen.sv
// Self-checking bench for qlearn_sa_gen (NUM_EPISODES=2, MAX_STEPS=4).
module tb_qlearn_sa_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_sa_ready, i_ns_valid;
  logic [5:0]  i_ns;
  logic        o_sa_valid, o_episode_done, o_busy, o_run_done;
  logic [5:0]  o_state;
  logic [1:0]  o_action;
  logic [7:0]  o_addr;
  logic [15:0] o_episode_cnt, o_step_cnt;

  always #5 clk = ~clk;

  qlearn_sa_gen #(
    .STATE_W(6), .ACTION_W(2), .START_STATE(0), .END_STATE(63),
    .MAX_STEPS(4), .NUM_EPISODES(2), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .o_sa_valid(o_sa_valid), .i_sa_ready(i_sa_ready),
    .o_state(o_state), .o_action(o_action), .o_addr(o_addr),
    .i_ns_valid(i_ns_valid), .i_ns(i_ns),
    .o_episode_done(o_episode_done), .o_episode_cnt(o_episode_cnt),
    .o_step_cnt(o_step_cnt), .o_busy(o_busy), .o_run_done(o_run_done)
  );

  typedef struct {
    logic [5:0]  state;
    logic [1:0]  action;
    logic        epd;
    logic        rund;
    logic [15:0] ep;
    logic [15:0] step;
    logic        busy;
    logic        valid;
  } exp_t;

  typedef struct {
    logic [5:0] ns;
    int         stall;
    logic [5:0] exp_state;
    logic       exp_epd;
    logic       exp_rund;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] m_lfsr;
  logic [5:0]  m_state;
  logic [1:0]  m_action;
  logic [15:0] m_step, m_ep;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare it with the current outputs
  task automatic compare_out(input string tag);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    n_tests--;
    e = sb.pop_front();
    chk({tag, ".state"},  32'(o_state),        32'(e.state));
    chk({tag, ".action"}, 32'(o_action),       32'(e.action));
    chk({tag, ".addr"},   32'(o_addr),         32'({e.state, e.action}));
    chk({tag, ".epd"},    32'(o_episode_done), 32'(e.epd));
    chk({tag, ".rund"},   32'(o_run_done),     32'(e.rund));
    chk({tag, ".epcnt"},  32'(o_episode_cnt),  32'(e.ep));
    chk({tag, ".step"},   32'(o_step_cnt),     32'(e.step));
    chk({tag, ".busy"},   32'(o_busy),         32'(e.busy));
    chk({tag, ".valid"},  32'(o_sa_valid),     32'(e.valid));
  endtask

  task automatic do_start(input string tag);
    exp_t e;
    i_start  = 1'b1;
    m_state  = 6'd0;
    m_action = m_lfsr[1:0];
    m_step   = 16'd0;
    m_ep     = 16'd0;
    e = '{state: m_state, action: m_action, epd: 1'b0, rund: 1'b0,
          ep: m_ep, step: m_step, busy: 1'b1, valid: 1'b1};
    sb.push_back(e);
    tick();
    i_start = 1'b0;
    compare_out(tag);
  endtask

  // Stall (with ignored ns pulses), then accept the current offer
  task automatic handshake(input string tag, input int stall);
    chk({tag, ".offer"}, 32'(o_sa_valid), 32'd1);
    for (int s = 0; s < stall; s++) begin
      i_sa_ready = 1'b0;
      i_ns_valid = 1'b1;
      i_ns       = 6'd63;
      tick();
      chk({tag, ".stall_valid"}, 32'(o_sa_valid), 32'd1);
      chk({tag, ".stall_addr"},  32'(o_addr),     32'({m_state, m_action}));
      chk({tag, ".stall_epd"},   32'(o_episode_done), 32'd0);
    end
    i_ns_valid = 1'b0;
    i_sa_ready = 1'b1;
    tick();
    i_sa_ready = 1'b0;
    chk({tag, ".hs_drop"}, 32'(o_sa_valid), 32'd0);
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic do_step(input string tag, input logic [5:0] ns, input int stall,
                         input logic [5:0] exp_state, input logic epd, input logic rund);
    exp_t e;
    handshake(tag, stall);
    if (epd) begin
      m_step = 16'd0;
      m_ep   = m_ep + 16'd1;
    end else begin
      m_step = m_step + 16'd1;
    end
    m_state = exp_state;
    if (!rund) m_action = m_lfsr[1:0];
    e = '{state: m_state, action: m_action, epd: epd, rund: rund,
          ep: m_ep, step: m_step, busy: !rund, valid: !rund};
    sb.push_back(e);
    i_ns_valid = 1'b1;
    i_ns       = ns;
    tick();
    i_ns_valid = 1'b0;
    compare_out(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(o_sa_valid),     32'd0);
    chk({tag, ".addr"},  32'(o_addr),         32'd0);
    chk({tag, ".epd"},   32'(o_episode_done), 32'd0);
    chk({tag, ".rund"},  32'(o_run_done),     32'd0);
    chk({tag, ".epcnt"}, 32'(o_episode_cnt),  32'd0);
    chk({tag, ".step"},  32'(o_step_cnt),     32'd0);
    chk({tag, ".busy"},  32'(o_busy),         32'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_sa_ready = 1'b0; i_ns_valid = 1'b0; i_ns = 6'd0;
    m_lfsr = SEED;
    vecs[0] = '{ns: 6'd5,  stall: 5, exp_state: 6'd5,  exp_epd: 1'b0, exp_rund: 1'b0};
    vecs[1] = '{ns: 6'd12, stall: 0, exp_state: 6'd12, exp_epd: 1'b0, exp_rund: 1'b0};
    vecs[2] = '{ns: 6'd63, stall: 2, exp_state: 6'd0,  exp_epd: 1'b1, exp_rund: 1'b0};
    vecs[3] = '{ns: 6'd20, stall: 0, exp_state: 6'd20, exp_epd: 1'b0, exp_rund: 1'b0};
    vecs[4] = '{ns: 6'd63, stall: 1, exp_state: 6'd0,  exp_epd: 1'b1, exp_rund: 1'b1};

    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset_idle");

    // First offer comes straight from the seed
    i_sa_ready = 1'b1;
    do_start("start1");
    i_sa_ready = 1'b0;
    chk("t1.action_seed", 32'(o_action), 32'h1);
    chk("t1.addr",        32'(o_addr),   32'h01);

    for (int i = 0; i < 5; i++) begin
      do_step($sformatf("runA[%0d]", i), vecs[i].ns, vecs[i].stall,
              vecs[i].exp_state, vecs[i].exp_epd, vecs[i].exp_rund);
      if (i == 2) chk("t3.epcnt_after_63", 32'(o_episode_cnt), 32'd1);
    end

    // After run end: idle, further next-state pulses ignored
    for (int i = 0; i < 3; i++) begin
      i_ns_valid = 1'b1;
      i_ns       = 6'd63;
      tick();
      chk("idle.valid", 32'(o_sa_valid),     32'd0);
      chk("idle.busy",  32'(o_busy),         32'd0);
      chk("idle.rund",  32'(o_run_done),     32'd0);
      chk("idle.epd",   32'(o_episode_done), 32'd0);
      chk("idle.epcnt", 32'(o_episode_cnt),  32'd2);
    end
    i_ns_valid = 1'b0;
    tick();

    // Step-limit behaviour with i_ns stuck at 7
    do_start("start2");
`ifdef QL_STEP_LIMIT_EN
    for (int i = 1; i <= 8; i++) begin
      do_step($sformatf("limit[%0d]", i), 6'd7, 0,
              (i % 4 == 0) ? 6'd0 : 6'd7, (i % 4 == 0), (i == 8));
    end
    chk("limit.busy_end", 32'(o_busy), 32'd0);
`else
    for (int i = 1; i <= 6; i++) begin
      do_step($sformatf("nolimit[%0d]", i), 6'd7, 0, 6'd7, 1'b0, 1'b0);
      if (i == 4) chk("nolimit.step4", 32'(o_step_cnt), 32'd4);
    end
    chk("nolimit.step6", 32'(o_step_cnt), 32'd6);
`endif

    // Reset in WAIT_NS drops the offer and clears outputs asynchronously
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_lfsr = SEED;
    tick();
    do_start("start3");
    handshake("rst_hs", 0);
    i_ns_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    m_lfsr = SEED;
    tick();
    check_all_zero("after_rst");
    do_start("start4");
    chk("t6.action_seed", 32'(o_action), 32'h1);
    do_step("rst_step", 6'd9, 0, 6'd9, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

endmodule
